// File: rtl/m7458_pkg.sv
// Shared constants for the 7458 clocked wrapper: counter width default and the
// all-ones saturation value for a given counter width.
package m7458_pkg;

  localparam int unsigned CntWDefault = 8;

  // All-ones value of a w-bit counter (w in 1..32).
  function automatic logic [31:0] sat_max(input int unsigned w);
    return 32'hFFFF_FFFF >> (32 - w);
  endfunction

endpackage

// File: rtl/m7458_edge_cnt.sv
// One section of the 7458 wrapper: registered gate output, 0->1 edge pulse and
// a saturating count of those pulses.
module m7458_edge_cnt
  import m7458_pkg::*;
#(
  parameter int unsigned CNT_W = CntWDefault
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             y,
  input  logic             cnt_clr,
  output logic             y_q,
  output logic             rise,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(sat_max(CNT_W));

  logic             yq_q;
  logic             rise_d, rise_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  // Edge is judged against the value captured on the previous clock.
  always_comb begin
    rise_d = y & ~yq_q;
    cnt_d  = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (rise_d && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      yq_q   <= 1'b0;
      rise_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      yq_q   <= y;
      rise_q <= rise_d;
      cnt_q  <= cnt_d;
    end
  end

  assign y_q  = yq_q;
  assign rise = rise_q;
  assign cnt  = cnt_q;

endmodule

// File: rtl/m7458_core.sv
// 7458 dual AND-OR gate with registered outputs, rise pulses and saturating
// rise counters for synchronous consumers.
module m7458_core
  import m7458_pkg::*;
#(
  parameter int unsigned CNT_W = CntWDefault
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             p1a,
  input  logic             p1b,
  input  logic             p1c,
  input  logic             p1d,
  input  logic             p1e,
  input  logic             p1f,
  input  logic             p2a,
  input  logic             p2b,
  input  logic             p2c,
  input  logic             p2d,
  input  logic             cnt_clr,
  output logic             p1y,
  output logic             p2y,
  output logic             p1y_q,
  output logic             p2y_q,
  output logic             p1_rise,
  output logic             p2_rise,
  output logic [CNT_W-1:0] p1_cnt,
  output logic [CNT_W-1:0] p2_cnt
);

  // Gate outputs are independent of clk and rst, so they stay live in reset.
  assign p1y = (p1a & p1b & p1c) | (p1d & p1e & p1f);
  assign p2y = (p2a & p2b) | (p2c & p2d);

  m7458_edge_cnt #(
    .CNT_W(CNT_W)
  ) u_sec1 (
    .clk    (clk),
    .rst    (rst),
    .y      (p1y),
    .cnt_clr(cnt_clr),
    .y_q    (p1y_q),
    .rise   (p1_rise),
    .cnt    (p1_cnt)
  );

  m7458_edge_cnt #(
    .CNT_W(CNT_W)
  ) u_sec2 (
    .clk    (clk),
    .rst    (rst),
    .y      (p2y),
    .cnt_clr(cnt_clr),
    .y_q    (p2y_q),
    .rise   (p2_rise),
    .cnt    (p2_cnt)
  );

endmodule

// File: tb/tb_m7458_core.sv
// Bench for m7458_core: combinational table and sweep, then a scoreboarded
// clocked sequence with hand checks for saturation, clear priority and reset.
module tb_m7458_core;

  logic       clk = 1'b0;
  logic       clk_en = 1'b0;
  logic       rst;
  logic [9:0] vec;
  logic       cnt_clr;

  logic       p1y, p2y, p1y_q, p2y_q, p1_rise, p2_rise;
  logic [7:0] p1_cnt, p2_cnt;
  logic       s_p1y, s_p2y, s_p1y_q, s_p2y_q, s_p1_rise, s_p2_rise;
  logic [1:0] s_p1_cnt, s_p2_cnt;

  int checks = 0;
  int failures = 0;

  always #5 if (clk_en) clk = ~clk;

  m7458_core dut (
    .clk(clk), .rst(rst),
    .p1a(vec[9]), .p1b(vec[8]), .p1c(vec[7]), .p1d(vec[6]), .p1e(vec[5]), .p1f(vec[4]),
    .p2a(vec[3]), .p2b(vec[2]), .p2c(vec[1]), .p2d(vec[0]),
    .cnt_clr(cnt_clr),
    .p1y(p1y), .p2y(p2y), .p1y_q(p1y_q), .p2y_q(p2y_q),
    .p1_rise(p1_rise), .p2_rise(p2_rise), .p1_cnt(p1_cnt), .p2_cnt(p2_cnt)
  );

  m7458_core #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst),
    .p1a(vec[9]), .p1b(vec[8]), .p1c(vec[7]), .p1d(vec[6]), .p1e(vec[5]), .p1f(vec[4]),
    .p2a(vec[3]), .p2b(vec[2]), .p2c(vec[1]), .p2d(vec[0]),
    .cnt_clr(cnt_clr),
    .p1y(s_p1y), .p2y(s_p2y), .p1y_q(s_p1y_q), .p2y_q(s_p2y_q),
    .p1_rise(s_p1_rise), .p2_rise(s_p2_rise), .p1_cnt(s_p1_cnt), .p2_cnt(s_p2_cnt)
  );

  typedef struct {
    logic [9:0] v;
    logic       e1;
    logic       e2;
  } comb_vec_t;

  typedef struct {
    logic       y1q, y2q, r1, r2;
    logic [7:0] c1, c2;
    logic [1:0] c1s;
  } exp_t;

  exp_t       sb_q[$];
  logic       m1q, m2q;
  logic [7:0] mc1, mc2;
  logic [1:0] mc1s;
  int         rise2_seen;

  function automatic logic ref1(input logic [9:0] v);
    return (v[9] & v[8] & v[7]) | (v[6] & v[5] & v[4]);
  endfunction

  function automatic logic ref2(input logic [9:0] v);
    return (v[3] & v[2]) | (v[1] & v[0]);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m1q = 1'b0; m2q = 1'b0; mc1 = '0; mc2 = '0; mc1s = '0;
  endtask

  // Drive one vector, predict the post-edge state, clock, then compare.
  task automatic step(input logic [9:0] v, input logic clr);
    exp_t e, got;
    logic y1, y2;
    vec = v;
    cnt_clr = clr;
    y1 = ref1(v);
    y2 = ref2(v);
    e.r1 = y1 & ~m1q;
    e.r2 = y2 & ~m2q;
    if (clr) begin
      mc1 = '0; mc2 = '0; mc1s = '0;
    end else begin
      if (e.r1 && mc1 != 8'hFF) mc1 = mc1 + 8'd1;
      if (e.r2 && mc2 != 8'hFF) mc2 = mc2 + 8'd1;
      if (e.r1 && mc1s != 2'b11) mc1s = mc1s + 2'd1;
    end
    m1q = y1;
    m2q = y2;
    e.y1q = y1; e.y2q = y2; e.c1 = mc1; e.c2 = mc2; e.c1s = mc1s;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    check("sb_p1y_q", p1y_q, got.y1q);
    check("sb_p2y_q", p2y_q, got.y2q);
    check("sb_p1_rise", p1_rise, got.r1);
    check("sb_p2_rise", p2_rise, got.r2);
    check("sb_p1_cnt", p1_cnt, got.c1);
    check("sb_p2_cnt", p2_cnt, got.c2);
    check("sb_sat_p1_cnt", s_p1_cnt, got.c1s);
    cnt_clr = 1'b0;
  endtask

  initial begin
    comb_vec_t tbl[8];
    logic [3:0] exp_p2yq[4];
    logic [1:0] exp_sat[5];
    logic [9:0] pat[4];

    tbl[0] = '{10'd0,   1'b0, 1'b0};
    tbl[1] = '{10'h3FF, 1'b1, 1'b1};
    tbl[2] = '{10'd12,  1'b0, 1'b1};
    tbl[3] = '{10'd23,  1'b0, 1'b1};
    tbl[4] = '{10'd253, 1'b1, 1'b1};
    tbl[5] = '{10'd256, 1'b0, 1'b0};
    tbl[6] = '{10'd93,  1'b0, 1'b1};
    tbl[7] = '{10'd48,  1'b0, 1'b0};

    rst = 1'b1;
    cnt_clr = 1'b0;
    vec = '0;
    model_reset();
    #3;

    check("rst_p1y_q", p1y_q, 0);
    check("rst_p2y_q", p2y_q, 0);
    check("rst_p1_rise", p1_rise, 0);
    check("rst_p2_rise", p2_rise, 0);
    check("rst_p1_cnt", p1_cnt, 0);
    check("rst_p2_cnt", p2_cnt, 0);

    // Clock stopped, reset held: gate outputs must still respond.
    for (int i = 0; i < 8; i++) begin
      vec = tbl[i].v;
      #1;
      check("tbl_p1y", p1y, tbl[i].e1);
      check("tbl_p2y", p2y, tbl[i].e2);
    end
    for (int i = 0; i < 1024; i++) begin
      vec = 10'(i);
      #1;
      check("sweep_p1y", p1y, ref1(vec));
      check("sweep_p2y", p2y, ref2(vec));
    end

    vec = '0;
    #1;
    rst = 1'b0;
    #1;
    clk_en = 1'b1;

    // Registered path: 0 -> 12 -> 12 -> 0.
    pat[0] = 10'd0; pat[1] = 10'd12; pat[2] = 10'd12; pat[3] = 10'd0;
    exp_p2yq[0] = 4'd0; exp_p2yq[1] = 4'd1; exp_p2yq[2] = 4'd1; exp_p2yq[3] = 4'd0;
    rise2_seen = 0;
    for (int i = 0; i < 4; i++) begin
      step(pat[i], 1'b0);
      check("reg_p2y_q", {3'b0, p2y_q}, exp_p2yq[i]);
      if (p2_rise) rise2_seen++;
    end
    check("reg_rise_once", rise2_seen, 1);
    check("reg_p2_cnt", p2_cnt, 1);
    check("reg_p1_cnt", p1_cnt, 0);

    // Saturation in the 2-bit instance.
    exp_sat[0] = 2'd1; exp_sat[1] = 2'd2; exp_sat[2] = 2'd3;
    exp_sat[3] = 2'd3; exp_sat[4] = 2'd3;
    for (int i = 0; i < 5; i++) begin
      step(10'h3F0, 1'b0);
      check("sat_p1_cnt", s_p1_cnt, exp_sat[i]);
      step(10'd0, 1'b0);
    end
    check("sat_wide_p1_cnt", p1_cnt, 5);

    // Clear on the same edge as a p2 rise.
    step(10'd12, 1'b1);
    check("clr_p2_cnt", p2_cnt, 0);
    check("clr_p2_rise", p2_rise, 1);
    check("clr_p1_cnt", p1_cnt, 0);
    step(10'd0, 1'b0);

    // Build p1_cnt = 2 then hit reset between edges.
    step(10'h3F0, 1'b0);
    step(10'd0, 1'b0);
    step(10'h3F0, 1'b0);
    check("pre_rst_p1_cnt", p1_cnt, 2);
    #2;
    rst = 1'b1;
    #1;
    check("arst_p1y_q", p1y_q, 0);
    check("arst_p1_rise", p1_rise, 0);
    check("arst_p1_cnt", p1_cnt, 0);
    check("arst_p2_cnt", p2_cnt, 0);
    check("arst_sat_p1_cnt", s_p1_cnt, 0);
    vec = 10'd0;
    #1;
    check("arst_p1y_lo", p1y, 0);
    vec = 10'h3F0;
    #1;
    check("arst_p1y_hi", p1y, 1);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // First edge after reset with p1y high reports a rise.
    step(10'h3F0, 1'b0);
    check("post_rst_p1_rise", p1_rise, 1);
    step(10'h3F0, 1'b0);
    check("hold_p1_rise", p1_rise, 0);
    check("hold_p1_cnt", p1_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
